morph_seq_ctrl: RTL and testbench
=================================

// Module: morph_seq_ctrl
// PURPOSE
//  Frame-synchronous sequencer for the binary morphology chain: two cascaded
//  3x3 stages, each selectable as bypass, erode or dilate.
//  Accepts mode requests from the key/UART control path and commits them only
//  on a frame boundary, so a frame is never processed with mixed settings.
//  Monitors frame geometry (pixels/line, lines/frame) and flags malformed or
//  stalled frames. Sits beside the pipeline and drives the stage-select muxes.
// PARAMETERS
//  H_ACT    640       active pixels per line (data_en_i high cycles)
//  V_ACT    480       active lines per frame
//  TIMEOUT  2000000   max clk cycles between frame starts before stall error
// PORTS
//  clk           in   1   pixel clock; all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  vsync_i       in   1   frame sync; rising edge = frame start
//  hsync_i       in   1   line sync (monitored only, not required for counting)
//  data_en_i     in   1   active-pixel qualifier
//  mode_req      in   3   0 bypass,1 erode,2 dilate,3 open(E->D),4 close(D->E)
//  mode_req_vld  in   1   1-cycle strobe, mode_req valid
//  mode_ack      out  1   1-cycle pulse: pending mode committed
//  cur_mode      out  3   mode in force for the current frame
//  stage1_sel    out  2   00 bypass, 01 erode, 10 dilate (11 never driven)
//  stage2_sel    out  2   same encoding, second stage
//  frame_done    out  1   1-cycle pulse: previous frame had correct geometry
//  frame_err     out  1   1-cycle pulse: geometry error or timeout
//  busy          out  1   1 while state = ACTIVE
// BEHAVIOUR
//  Reset: all outputs 0, cur_mode=0 (bypass), pending empty, state IDLE,
//   counters 0. Reset mid-frame discards pending request and counts.
//  vs_rise = vsync_i & ~vsync_d (vsync_d registered copy); 1-cycle detect.
//  Request: mode_req_vld with mode_req<=4 loads pending, sets pend_vld;
//   later request before commit overwrites it; codes 5..7 ignored (no ack).
//  Commit: on vs_rise with pend_vld: cur_mode, stage sels update the SAME edge
//   as vs_rise is registered (outputs valid cycle after vsync_i rises);
//   mode_ack pulses that cycle; pend_vld clears. Request and vs_rise same
//   cycle: new request committed (write-through).
//  Sel map: 0->00/00, 1->01/00, 2->10/00, 3->01/10, 4->10/01.
//  FSM: IDLE -vs_rise-> ACTIVE (no done/err on first frame).
//   ACTIVE -vs_rise-> ACTIVE: evaluate closing frame, pulse done or err,
//   clear counters. ACTIVE -wd_cnt==TIMEOUT-1-> IDLE, pulse frame_err.
//  Counting: pix_cnt (10b) +1 per data_en_i cycle; on data_en_i falling edge
//   compare pix_cnt==H_ACT (else latch line_bad), clear pix_cnt, line_cnt+1.
//   line_cnt saturates at 1023. Frame OK iff !line_bad & line_cnt==V_ACT.
//  A line still active (data_en_i=1) at vs_rise counts as a short line: err.
//  wd_cnt clears on vs_rise, increments otherwise in ACTIVE; held 0 in IDLE.
//  frame_done and frame_err never assert in the same cycle.
//  Latency: request->commit bounded by one frame; stage select is constant
//   between consecutive vs_rise events.
// TESTING
//  1 Reset, 3 frames 640x480, no requests -> frame_done x2, cur_mode=0, no err.
//  2 mode_req=3 vld mid-frame 1 -> sels stay 00/00 until next vs_rise, then
//    01/10, cur_mode=3, mode_ack 1 cycle.
//  3 req 1 then req 4 same frame -> only 4 committed (10/01), one ack; req 6 ->
//    ignored, no ack.
//  4 Frame with line 100 of 639 pixels -> frame_err at next vs_rise, no done;
//    frame of 479 lines -> frame_err.
//  5 TIMEOUT=1000, stop vsync after frame 1 -> frame_err at cycle 1000 after
//    last vs_rise, busy->0; next vs_rise -> ACTIVE, no pulse.
//  6 Assert rst mid-frame with pending req -> outputs 0, pending lost, next
//    vs_rise gives no ack.

Source files
------------

// File: rtl/morph_seq_ctrl.sv
`timescale 1ns/1ps
// morph_seq_ctrl
//   Frame-synchronous sequencer for the two-stage 3x3 binary morphology chain.
//   Mode requests are held as pending and committed only on a frame start, so
//   a frame is never processed with mixed stage settings. Frame geometry
//   (pixels per line, lines per frame) is checked, and stalled frames are
//   detected with a watchdog.
// Ports
//   clk, rst                 pixel clock, synchronous active-high reset
//   vsync_i                  frame sync; a rising edge starts a frame
//   hsync_i                  line sync (observed only)
//   data_en_i                active-pixel qualifier
//   mode_req, mode_req_vld   mode request (0..4) and its 1-cycle strobe
//   mode_ack                 1-cycle pulse when a pending mode is committed
//   cur_mode                 mode in force for the current frame
//   stage1_sel, stage2_sel   00 bypass, 01 erode, 10 dilate
//   frame_done, frame_err    1-cycle verdict on the frame that just closed
//   busy                     high while a frame is being tracked
module morph_seq_ctrl #(
   parameter int unsigned H_ACT   = 640,
   parameter int unsigned V_ACT   = 480,
   parameter int unsigned TIMEOUT = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync_i,
   input  logic       hsync_i,
   input  logic       data_en_i,
   input  logic [2:0] mode_req,
   input  logic       mode_req_vld,
   output logic       mode_ack,
   output logic [2:0] cur_mode,
   output logic [1:0] stage1_sel,
   output logic [1:0] stage2_sel,
   output logic       frame_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t         state_q;
   logic           vsync_q, de_q, skip_q, line_bad_q;
   logic           pend_vld_q;
   logic [2:0]     pend_q;
   logic [9:0]     pix_cnt_q, line_cnt_q;
   logic [WDW-1:0] wd_cnt_q;
   logic           mode_ack_q, frame_done_q, frame_err_q, busy_q;
   logic [2:0]     cur_mode_q;
   logic [1:0]     s1_q, s2_q;

   logic           vs_rise, de_fall, req_ok, line_end, end_bad, frame_ok;
   logic [9:0]     lines_closed;
   logic [2:0]     commit_mode;
   logic           unused_hsync;

   assign unused_hsync = hsync_i;

   function automatic logic [3:0] sel_map(input logic [2:0] m);
      case (m)
         3'd1:    sel_map = 4'b01_00;
         3'd2:    sel_map = 4'b10_00;
         3'd3:    sel_map = 4'b01_10;
         3'd4:    sel_map = 4'b10_01;
         default: sel_map = 4'b00_00;
      endcase
   endfunction

   always_comb begin
      vs_rise     = vsync_i & ~vsync_q;
      de_fall     = de_q & ~data_en_i;
      req_ok      = mode_req_vld & (mode_req <= 3'd4);
      // A request arriving together with vs_rise wins over the pending one.
      commit_mode = req_ok ? mode_req : pend_q;
      // Lines truncated by a frame start are skipped until data_en_i drops.
      line_end    = de_fall & ~skip_q;
      end_bad     = line_end & (pix_cnt_q != 10'(H_ACT));
      lines_closed = (line_end && (line_cnt_q != '1)) ? line_cnt_q + 10'd1 : line_cnt_q;
      // Verdict includes a line that ends on the very cycle of vs_rise;
      // a line still active at vs_rise is short by definition.
      frame_ok    = ~line_bad_q & ~end_bad & ~data_en_i & (lines_closed == 10'(V_ACT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         vsync_q      <= 1'b0;
         de_q         <= 1'b0;
         skip_q       <= 1'b0;
         line_bad_q   <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_q       <= '0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         wd_cnt_q     <= '0;
         mode_ack_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
         cur_mode_q   <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
      end else begin
         vsync_q      <= vsync_i;
         de_q         <= data_en_i;
         mode_ack_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (vs_rise) begin
            if (req_ok || pend_vld_q) begin
               cur_mode_q     <= commit_mode;
               {s1_q, s2_q}   <= sel_map(commit_mode);
               mode_ack_q     <= 1'b1;
            end
            pend_vld_q <= 1'b0;
         end else if (req_ok) begin
            pend_q     <= mode_req;
            pend_vld_q <= 1'b1;
         end

         if (vs_rise) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            line_bad_q <= 1'b0;
            skip_q     <= data_en_i;
         end else if (skip_q) begin
            if (!data_en_i) skip_q <= 1'b0;
         end else if (de_fall) begin
            line_bad_q <= line_bad_q | end_bad;
            line_cnt_q <= lines_closed;
            pix_cnt_q  <= '0;
         end else if (data_en_i && (pix_cnt_q != '1)) begin
            pix_cnt_q <= pix_cnt_q + 10'd1;
         end

         case (state_q)
            S_IDLE: begin
               wd_cnt_q <= '0;
               if (vs_rise) begin
                  state_q <= S_ACTIVE;
                  busy_q  <= 1'b1;
               end
            end
            S_ACTIVE: begin
               if (vs_rise) begin
                  wd_cnt_q     <= '0;
                  frame_done_q <= frame_ok;
                  frame_err_q  <= ~frame_ok;
               end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
                  wd_cnt_q    <= '0;
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  frame_err_q <= 1'b1;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mode_ack   = mode_ack_q;
   assign cur_mode   = cur_mode_q;
   assign stage1_sel = s1_q;
   assign stage2_sel = s2_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_morph_seq_ctrl.sv
`timescale 1ns/1ps
module tb_morph_seq_ctrl;

   localparam int H = 16;
   localparam int V = 8;
   localparam int TO = 1000;

   logic       clk = 1'b0;
   logic       rst, vsync, hsync, de, mvld;
   logic [2:0] mreq;
   logic       mode_ack, frame_done, frame_err, busy;
   logic [2:0] cur_mode;
   logic [1:0] s1, s2;

   morph_seq_ctrl #(.H_ACT(H), .V_ACT(V), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .vsync_i(vsync), .hsync_i(hsync), .data_en_i(de),
      .mode_req(mreq), .mode_req_vld(mvld), .mode_ack(mode_ack),
      .cur_mode(cur_mode), .stage1_sel(s1), .stage2_sel(s2),
      .frame_done(frame_done), .frame_err(frame_err), .busy(busy));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cnt_ack = 0, cnt_done = 0, cnt_err = 0, cnt_both = 0;
   int a0, d0, e0;

   always @(negedge clk) if (!rst) begin
      cnt_ack  += int'(mode_ack);
      cnt_done += int'(frame_done);
      cnt_err  += int'(frame_err);
      cnt_both += int'(frame_done & frame_err);
   end

   // reference model: mode in force, pending request, frame tracking
   logic [2:0] m_mode, m_pend;
   bit         m_pend_vld, m_active, m_prev_ok;
   bit         e_ack, e_done, e_err;

   // frame description for the next frame_body
   int         f_lines, f_bad_line, f_bad_len, f_nreq;
   bit         f_hold_de, f_vs_req;
   logic [2:0] f_vs_code;
   int         f_req_line[2];
   logic [2:0] f_req_code[2];

   function automatic logic [3:0] exp_sel(input logic [2:0] m);
      case (m)
         3'd1:    return 4'b0100;
         3'd2:    return 4'b1000;
         3'd3:    return 4'b0110;
         3'd4:    return 4'b1001;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_frame();
      f_lines = V; f_bad_line = -1; f_bad_len = H; f_nreq = 0;
      f_hold_de = 0; f_vs_req = 0; f_vs_code = 0;
   endtask

   task automatic model_reset();
      m_mode = 0; m_pend = 0; m_pend_vld = 0; m_active = 0; m_prev_ok = 0;
   endtask

   task automatic frame_start(input string tag);
      a0 = cnt_ack; d0 = cnt_done; e0 = cnt_err;
      e_ack = 0; e_done = 0; e_err = 0;
      if (f_vs_req && f_vs_code <= 3'd4) begin m_mode = f_vs_code; e_ack = 1; end
      else if (m_pend_vld) begin m_mode = m_pend; e_ack = 1; end
      m_pend_vld = 0;
      if (m_active) begin e_done = m_prev_ok; e_err = !m_prev_ok; end
      m_active = 1;
      vsync = 1;
      if (f_vs_req) begin mreq = f_vs_code; mvld = 1; end
      tick();
      mvld = 0; de = 0;
      n_cmp++; if (mode_ack !== e_ack) begin n_bad++; $display("FAIL %s start ack: got %b want %b", tag, mode_ack, e_ack); end
      n_cmp++; if (cur_mode !== m_mode) begin n_bad++; $display("FAIL %s start mode: got %0d want %0d", tag, cur_mode, m_mode); end
      n_cmp++; if ({s1, s2} !== exp_sel(m_mode)) begin n_bad++; $display("FAIL %s start sel: got %b want %b", tag, {s1, s2}, exp_sel(m_mode)); end
      n_cmp++; if (frame_done !== e_done) begin n_bad++; $display("FAIL %s start done: got %b want %b", tag, frame_done, e_done); end
      n_cmp++; if (frame_err !== e_err) begin n_bad++; $display("FAIL %s start err: got %b want %b", tag, frame_err, e_err); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s start busy: got %b want 1", tag, busy); end
   endtask

   task automatic frame_body(input string tag);
      bit bad = 0;
      tick(); vsync = 0;
      repeat (2) tick();
      for (int l = 0; l < f_lines; l++) begin
         int len;
         len = (l == f_bad_line) ? f_bad_len : H;
         if (len != H) bad = 1;
         de = 1; hsync = 1;
         repeat (len) tick();
         if (l == f_lines - 1 && f_hold_de) break;
         de = 0; hsync = 0;
         for (int r = 0; r < f_nreq; r++) if (f_req_line[r] == l) begin
            mreq = f_req_code[r]; mvld = 1; tick(); mvld = 0;
            if (f_req_code[r] <= 3'd4) begin m_pend = f_req_code[r]; m_pend_vld = 1; end
         end
         repeat (2 + $urandom_range(0, 3)) tick();
      end
      m_prev_ok = !bad && (f_lines == V) && !f_hold_de;
      n_cmp++; if ({s1, s2} !== exp_sel(m_mode)) begin n_bad++; $display("FAIL %s end sel held: got %b want %b", tag, {s1, s2}, exp_sel(m_mode)); end
      n_cmp++; if (cnt_ack - a0 !== int'(e_ack)) begin n_bad++; $display("FAIL %s ack count: got %0d want %0d", tag, cnt_ack - a0, e_ack); end
      n_cmp++; if (cnt_done - d0 !== int'(e_done)) begin n_bad++; $display("FAIL %s done count: got %0d want %0d", tag, cnt_done - d0, e_done); end
      n_cmp++; if (cnt_err - e0 !== int'(e_err)) begin n_bad++; $display("FAIL %s err count: got %0d want %0d", tag, cnt_err - e0, e_err); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s end busy: got %b want 1", tag, busy); end
   endtask

   task automatic run_frame(input string tag);
      frame_start(tag);
      frame_body(tag);
      clear_frame();
   endtask

   task automatic check_idle_outputs(input string tag);
      n_cmp++; if ({mode_ack, cur_mode, s1, s2, frame_done, frame_err, busy} !== 11'd0) begin
         n_bad++; $display("FAIL %s outputs: got %b want 0", tag, {mode_ack, cur_mode, s1, s2, frame_done, frame_err, busy});
      end
   endtask

   task automatic test_reset();
      rst = 1; vsync = 0; hsync = 0; de = 0; mreq = 0; mvld = 0;
      repeat (3) tick();
      rst = 0;
      model_reset(); clear_frame();
      check_idle_outputs("reset");
      tick();
      check_idle_outputs("reset+1");
   endtask

   task automatic test_basic_frames();
      repeat (3) run_frame("basic");
   endtask

   task automatic test_mode_commit();
      f_nreq = 1; f_req_line[0] = 3; f_req_code[0] = 3'd3;
      run_frame("commit_req");
      run_frame("commit_apply");
   endtask

   task automatic test_overwrite_and_illegal();
      f_nreq = 2; f_req_line[0] = 1; f_req_code[0] = 3'd1; f_req_line[1] = 4; f_req_code[1] = 3'd4;
      run_frame("overwrite_req");
      run_frame("overwrite_apply");
      f_nreq = 1; f_req_line[0] = 2; f_req_code[0] = 3'd6;
      run_frame("illegal_req");
      run_frame("illegal_apply");
   endtask

   task automatic test_write_through();
      f_vs_req = 1; f_vs_code = 3'd2;
      run_frame("wt_plain");
      f_nreq = 1; f_req_line[0] = 0; f_req_code[0] = 3'd1;
      run_frame("wt_pend");
      f_vs_req = 1; f_vs_code = 3'd0;
      run_frame("wt_override");
   endtask

   task automatic test_geometry();
      f_bad_line = 3; f_bad_len = H - 1;
      run_frame("short_line");
      f_lines = V - 1;
      run_frame("short_frame");
      f_hold_de = 1;
      run_frame("de_at_vs");
      run_frame("after_trunc");
      run_frame("geo_recover");
   endtask

   task automatic test_timeout();
      int k;
      frame_start("to_start");
      vsync = 0;
      k = 1;
      while (k <= TO + 100) begin
         tick();
         if (frame_err === 1'b1) break;
         k++;
      end
      n_cmp++; if (k !== TO) begin n_bad++; $display("FAIL timeout cycle: got %0d want %0d", k, TO); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout busy: got %b want 0", busy); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL timeout done: got %b want 0", frame_done); end
      m_active = 0;
      repeat (5) tick();
      run_frame("to_restart");
   endtask

   task automatic test_reset_mid_frame();
      frame_start("rstmid_start");
      tick(); vsync = 0;
      repeat (3) tick();
      mreq = 3'd2; mvld = 1; tick(); mvld = 0;
      de = 1; repeat (5) tick();
      rst = 1; tick(); tick(); rst = 0; de = 0;
      model_reset(); clear_frame();
      check_idle_outputs("rstmid");
      repeat (3) tick();
      run_frame("rstmid_next");
      run_frame("rstmid_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 14; i++) begin
         int p;
         clear_frame();
         p = $urandom_range(0, 9);
         if (p == 0) f_lines = V - 1;
         else if (p == 1) f_lines = V + 1;
         if ($urandom_range(0, 3) == 0) begin
            f_bad_line = $urandom_range(0, V - 1);
            f_bad_len = $urandom_range(1, H + 3);
         end
         f_hold_de = ($urandom_range(0, 7) == 0);
         f_nreq = $urandom_range(0, 2);
         for (int r = 0; r < 2; r++) begin
            f_req_line[r] = $urandom_range(0, V - 1);
            f_req_code[r] = 3'($urandom_range(0, 7));
         end
         f_vs_req = ($urandom_range(0, 3) == 0);
         f_vs_code = 3'($urandom_range(0, 7));
         frame_start("random");
         frame_body("random");
      end
      clear_frame();
      run_frame("random_tail");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_frames();
      test_mode_commit();
      test_overwrite_and_illegal();
      test_write_through();
      test_geometry();
      test_timeout();
      test_reset_mid_frame();
      test_random();
      n_cmp++; if (cnt_both !== 0) begin n_bad++; $display("FAIL done_err_overlap: got %0d want 0", cnt_both); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
